// File: rtl/mips_mc_ctrl_if.sv
// Control-unit bundle: instruction fields and ALU flags into the FSM, strobes and
// the registered control word back out to the datapath.
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       br_cond;
  logic       ovf;
  logic       mem_ready;
  logic [2:0] state;
  logic       pc_wr;
  logic       ir_wr;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_wr;
  logic       reg_dst;
  logic       ext_op;
  logic       alu_src;
  logic       mem_to_reg;
  logic       shamt_ctr;
  logic       jump;
  logic       jump_reg;
  logic       link;
  logic [4:0] alu_ctr;
  logic [1:0] byte_width;
  logic       dm_sign_ext;
  logic       exc;
  logic [1:0] exc_code;

  modport master (
    input  opcode, funct, rt, br_cond, ovf, mem_ready,
    output state, pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, ext_op, alu_src,
           mem_to_reg, shamt_ctr, jump, jump_reg, link, alu_ctr, byte_width,
           dm_sign_ext, exc, exc_code
  );

  modport slave (
    output opcode, funct, rt, br_cond, ovf, mem_ready,
    input  state, pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, ext_op, alu_src,
           mem_to_reg, shamt_ctr, jump, jump_reg, link, alu_ctr, byte_width,
           dm_sign_ext, exc, exc_code
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: decodes the IR into a registered control word and sequences
// fetch, decode, execute, memory and write-back, trapping on illegal ops, overflow and timeouts.
module mips_mc_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter bit          EN_BYTE = 1'b1,
  parameter bit          EN_HALF = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mips_mc_ctrl_if.master ctrl_io
);

  typedef enum logic [2:0] {
    StFetch = 3'd0, StDecode = 3'd1, StExec = 3'd2, StMem = 3'd3, StWb = 3'd4, StExc = 3'd5
  } state_e;

  typedef enum logic [2:0] {KAlu, KLoad, KStore, KBranch, KJr, KJalr, KJump, KJal} kind_e;

  typedef struct packed {
    kind_e      kind;
    logic       ovf_chk;
    logic       reg_dst;
    logic       ext_op;
    logic       alu_src;
    logic       mem_to_reg;
    logic       shamt_ctr;
    logic [4:0] alu_ctr;
    logic [1:0] byte_width;
    logic       dm_sign_ext;
  } word_t;

  state_e     state_q, state_d;
  word_t      word_q, word_d, dec;
  logic       illegal;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d;
  logic       rst_q, hold, timeout_hit;
  logic       pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, exc, jump, jump_reg, link;

  always_comb begin
    dec            = '0;
    dec.byte_width = 2'b11;
    illegal        = 1'b0;
    case (ctrl_io.opcode)
      6'b000000: begin
        dec.reg_dst = 1'b1;
        case (ctrl_io.funct)
          6'b100000: begin dec.alu_ctr = 5'd1;  dec.ovf_chk   = 1'b1; end
          6'b100001: dec.alu_ctr = 5'd1;
          6'b100010: begin dec.alu_ctr = 5'd2;  dec.ovf_chk   = 1'b1; end
          6'b100011: dec.alu_ctr = 5'd2;
          6'b100100: dec.alu_ctr = 5'd3;
          6'b100101: dec.alu_ctr = 5'd4;
          6'b100110: dec.alu_ctr = 5'd5;
          6'b100111: dec.alu_ctr = 5'd6;
          6'b101010: dec.alu_ctr = 5'd7;
          6'b101011: dec.alu_ctr = 5'd8;
          6'b000000: begin dec.alu_ctr = 5'd9;  dec.shamt_ctr = 1'b1; end
          6'b000010: begin dec.alu_ctr = 5'd10; dec.shamt_ctr = 1'b1; end
          6'b000011: begin dec.alu_ctr = 5'd11; dec.shamt_ctr = 1'b1; end
          6'b000100: dec.alu_ctr = 5'd9;
          6'b000110: dec.alu_ctr = 5'd10;
          6'b000111: dec.alu_ctr = 5'd11;
          6'b001000: dec.kind = KJr;
          6'b001001: dec.kind = KJalr;
          default:   illegal = 1'b1;
        endcase
      end
      6'b000001: begin
        dec.kind = KBranch;
        if (ctrl_io.rt == 5'b00001)      dec.alu_ctr = 5'd14;
        else if (ctrl_io.rt == 5'b00000) dec.alu_ctr = 5'd17;
        else                             illegal = 1'b1;
      end
      6'b000010: dec.kind = KJump;
      6'b000011: dec.kind = KJal;
      6'b000100: begin dec.kind = KBranch; dec.alu_ctr = 5'd12; end
      6'b000101: begin dec.kind = KBranch; dec.alu_ctr = 5'd13; end
      6'b000111: begin dec.kind = KBranch; dec.alu_ctr = 5'd15; end
      6'b000110: begin dec.kind = KBranch; dec.alu_ctr = 5'd16; end
      6'b001000: begin dec.alu_ctr = 5'd1;  dec.alu_src = 1'b1; dec.ext_op = 1'b1;
                       dec.ovf_chk = 1'b1; end
      6'b001001: begin dec.alu_ctr = 5'd1;  dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
      6'b001010: begin dec.alu_ctr = 5'd7;  dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
      6'b001011: begin dec.alu_ctr = 5'd8;  dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
      6'b001100: begin dec.alu_ctr = 5'd3;  dec.alu_src = 1'b1; end
      6'b001101: begin dec.alu_ctr = 5'd4;  dec.alu_src = 1'b1; end
      6'b001110: begin dec.alu_ctr = 5'd5;  dec.alu_src = 1'b1; end
      6'b001111: begin dec.alu_ctr = 5'd18; dec.alu_src = 1'b1; end
      6'b100000: begin dec.kind = KLoad; dec.byte_width = 2'b01; dec.dm_sign_ext = 1'b1;
                       illegal = !EN_BYTE; end
      6'b100100: begin dec.kind = KLoad; dec.byte_width = 2'b01; illegal = !EN_BYTE; end
      6'b100001: begin dec.kind = KLoad; dec.byte_width = 2'b10; dec.dm_sign_ext = 1'b1;
                       illegal = !EN_HALF; end
      6'b100101: begin dec.kind = KLoad; dec.byte_width = 2'b10; illegal = !EN_HALF; end
      6'b100011: dec.kind = KLoad;
      6'b101000: begin dec.kind = KStore; dec.byte_width = 2'b01; illegal = !EN_BYTE; end
      6'b101001: begin dec.kind = KStore; dec.byte_width = 2'b10; illegal = !EN_HALF; end
      6'b101011: dec.kind = KStore;
      default:   illegal = 1'b1;
    endcase
    // Memory ops share the address-add setup; branches sign-extend their offset.
    if (dec.kind inside {KLoad, KStore}) begin
      dec.alu_ctr    = 5'd1;
      dec.alu_src    = 1'b1;
      dec.ext_op     = 1'b1;
      dec.mem_to_reg = (dec.kind == KLoad);
    end
    if (dec.kind == KBranch) dec.ext_op = 1'b1;
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 8'(TIMEOUT));
  // Outputs sit at reset values only while reset has been held across an edge.
  assign hold        = rst_i & rst_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    word_d   = word_q;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    reg_wr   = 1'b0;
    exc      = 1'b0;
    jump     = 1'b0;
    jump_reg = 1'b0;
    link     = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_rd = 1'b1;
        if (ctrl_io.mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = StDecode;
        end else if (timeout_hit) begin
          state_d = StExc;
          code_d  = 2'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDecode: begin
        word_d = dec;
        if (illegal) begin
          state_d = StExc;
          code_d  = 2'd1;
        end else if (dec.kind inside {KJump, KJal}) begin
          pc_wr   = 1'b1;
          jump    = 1'b1;
          link    = (dec.kind == KJal);
          reg_wr  = (dec.kind == KJal);
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (word_q.kind)
          KBranch: begin pc_wr = ctrl_io.br_cond; state_d = StFetch; end
          KJr:     begin pc_wr = 1'b1; jump_reg = 1'b1; state_d = StFetch; end
          KJalr: begin
            pc_wr    = 1'b1;
            jump_reg = 1'b1;
            reg_wr   = 1'b1;
            link     = 1'b1;
            state_d  = StFetch;
          end
          KLoad, KStore: state_d = StMem;
          default: begin
            if (word_q.ovf_chk && ctrl_io.ovf) begin
              state_d = StExc;
              code_d  = 2'd2;
            end else begin
              state_d = StWb;
            end
          end
        endcase
      end
      StMem: begin
        mem_rd = (word_q.kind == KLoad);
        mem_wr = (word_q.kind != KLoad);
        if (ctrl_io.mem_ready) begin
          state_d = (word_q.kind == KLoad) ? StWb : StFetch;
        end else if (timeout_hit) begin
          state_d = StExc;
          code_d  = 2'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWb: begin
        reg_wr  = 1'b1;
        state_d = StFetch;
      end
      StExc: begin
        exc     = 1'b1;
        pc_wr   = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (hold) begin
      {pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, exc, jump, jump_reg, link} = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
    if (rst_i) begin
      state_q           <= StFetch;
      cnt_q             <= '0;
      code_q            <= '0;
      word_q            <= '0;
      word_q.byte_width <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      word_q  <= word_d;
    end
  end

  assign ctrl_io.state       = state_q;
  assign ctrl_io.pc_wr       = pc_wr;
  assign ctrl_io.ir_wr       = ir_wr;
  assign ctrl_io.mem_rd      = mem_rd;
  assign ctrl_io.mem_wr      = mem_wr;
  assign ctrl_io.reg_wr      = reg_wr;
  assign ctrl_io.exc         = exc;
  assign ctrl_io.jump        = jump;
  assign ctrl_io.jump_reg    = jump_reg;
  assign ctrl_io.link        = link;
  assign ctrl_io.reg_dst     = word_q.reg_dst;
  assign ctrl_io.ext_op      = word_q.ext_op;
  assign ctrl_io.alu_src     = word_q.alu_src;
  assign ctrl_io.mem_to_reg  = word_q.mem_to_reg;
  assign ctrl_io.shamt_ctr   = word_q.shamt_ctr;
  assign ctrl_io.alu_ctr     = word_q.alu_ctr;
  assign ctrl_io.byte_width  = word_q.byte_width;
  assign ctrl_io.dm_sign_ext = word_q.dm_sign_ext;
  assign ctrl_io.exc_code    = code_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: scripted instruction sequences push per-cycle expectations into
// a scoreboard that is drained and compared on each falling edge.
module tb_mips_mc_ctrl;

  localparam logic [2:0] StFetch = 3'd0, StDecode = 3'd1, StExec = 3'd2;
  localparam logic [2:0] StMem = 3'd3, StWb = 3'd4, StExc = 3'd5;

  // Strobe vector order: pc_wr ir_wr mem_rd mem_wr reg_wr exc jump jump_reg link
  localparam logic [8:0] SPc  = 9'b100000000, SIr  = 9'b010000000, SRd = 9'b001000000;
  localparam logic [8:0] SWr  = 9'b000100000, SReg = 9'b000010000, SExc = 9'b000001000;
  localparam logic [8:0] SJmp = 9'b000000100, SJr  = 9'b000000010, SLnk = 9'b000000001;
  localparam logic [8:0] SFetchOk = SPc | SIr | SRd;

  typedef struct packed {
    logic [2:0] state;
    logic [8:0] stb;
    logic       chk_aux;
    logic [9:0] aux;
  } exp_t;

  logic       clk, rst;
  logic [5:0] opcode, funct;
  logic [4:0] rt;
  logic       br_cond, ovf, mem_ready;
  int         n_tests, n_fail;
  exp_t       sb_q[$];
  exp_t       mon_e;

  mips_mc_ctrl_if if1 ();
  mips_mc_ctrl_if if2 ();

  assign if1.opcode = opcode;  assign if2.opcode = opcode;
  assign if1.funct  = funct;   assign if2.funct  = funct;
  assign if1.rt     = rt;      assign if2.rt     = rt;
  assign if1.br_cond = br_cond; assign if2.br_cond = br_cond;
  assign if1.ovf    = ovf;     assign if2.ovf    = ovf;
  assign if1.mem_ready = mem_ready; assign if2.mem_ready = mem_ready;

  mips_mc_ctrl #(.TIMEOUT(15), .EN_BYTE(1'b1), .EN_HALF(1'b1)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .ctrl_io(if1)
  );

  mips_mc_ctrl #(.TIMEOUT(15), .EN_BYTE(1'b0), .EN_HALF(1'b0)) dut_nh (
    .clk_i  (clk),
    .rst_i  (rst),
    .ctrl_io(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] mk_aux(input logic [4:0] alu, input logic [1:0] bw,
                                        input logic dm, input logic [1:0] code);
    return {alu, bw, dm, code};
  endfunction

  function automatic logic [8:0] obs_stb();
    return {if1.pc_wr, if1.ir_wr, if1.mem_rd, if1.mem_wr, if1.reg_wr, if1.exc,
            if1.jump, if1.jump_reg, if1.link};
  endfunction

  function automatic logic [9:0] obs_aux();
    return {if1.alu_ctr, if1.byte_width, if1.dm_sign_ext, if1.exc_code};
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("state", 32'(if1.state), 32'(mon_e.state));
      chk("strobes", 32'(obs_stb()), 32'(mon_e.stb));
      if (mon_e.chk_aux) chk("ctrl_word", 32'(obs_aux()), 32'(mon_e.aux));
    end
  end

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
    opcode = op;
    funct  = fn;
    rt     = r;
  endtask

  task automatic cyc(input logic rdy, input logic brc, input logic ov, input logic [2:0] st,
                     input logic [8:0] stb, input logic ca, input logic [9:0] aux);
    exp_t e;
    mem_ready = rdy;
    br_cond   = brc;
    ovf       = ov;
    e         = '{state: st, stb: stb, chk_aux: ca, aux: aux};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rdy, input logic [2:0] st, input logic [8:0] stb);
    cyc(rdy, 1'b0, 1'b0, st, stb, 1'b0, '0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    instr(6'd0, 6'd0, 5'd0);
    br_cond = 1'b0; ovf = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(if1.state), 32'(StFetch));
    chk("rst_strobes", 32'(obs_stb()), 32'd0);
    chk("rst_word", 32'(obs_aux()), 32'(mk_aux(5'd0, 2'b11, 1'b0, 2'd0)));
    rst = 1'b0;

    // addu: 4-cycle ALU op
    instr(6'b000000, 6'b100001, 5'd0);
    step(1'b1, StFetch, SFetchOk);
    step(1'b0, StDecode, 9'd0);
    cyc(1'b0, 1'b0, 1'b0, StExec, 9'd0, 1'b1, mk_aux(5'd1, 2'b11, 1'b0, 2'd0));
    step(1'b0, StWb, SReg);

    // lh with three memory waits; the half-disabled instance must trap as illegal
    instr(6'b100001, 6'd0, 5'd0);
    step(1'b1, StFetch, SFetchOk);
    step(1'b0, StDecode, 9'd0);
    chk("nh_state", 32'(if2.state), 32'(StExc));
    chk("nh_exc", 32'(if2.exc), 32'd1);
    chk("nh_code", 32'(if2.exc_code), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, StExec, 9'd0, 1'b1, mk_aux(5'd1, 2'b10, 1'b1, 2'd0));
    repeat (3) step(1'b0, StMem, SRd);
    step(1'b1, StMem, SRd);
    cyc(1'b0, 1'b0, 1'b0, StWb, SReg, 1'b1, mk_aux(5'd1, 2'b10, 1'b1, 2'd0));

    // add with overflow traps with code 2 and no register write
    instr(6'b000000, 6'b100000, 5'd0);
    step(1'b1, StFetch, SFetchOk);
    step(1'b0, StDecode, 9'd0);
    cyc(1'b0, 1'b0, 1'b1, StExec, 9'd0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, StExc, SPc | SExc, 1'b1, mk_aux(5'd1, 2'b11, 1'b0, 2'd2));

    // addu ignores overflow; stray mem_ready in DECODE/EXEC is ignored
    instr(6'b000000, 6'b100001, 5'd0);
    step(1'b1, StFetch, SFetchOk);
    step(1'b1, StDecode, 9'd0);
    cyc(1'b1, 1'b0, 1'b1, StExec, 9'd0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, StWb, SReg, 1'b1, mk_aux(5'd1, 2'b11, 1'b0, 2'd2));

    // fetch timeout: 16 waiting cycles then a bus-error trap
    repeat (16) step(1'b0, StFetch, SRd);
    cyc(1'b0, 1'b0, 1'b0, StExc, SPc | SExc, 1'b1, mk_aux(5'd1, 2'b11, 1'b0, 2'd0));

    // ready on the 16th cycle wins over the timeout
    repeat (15) step(1'b0, StFetch, SRd);
    step(1'b1, StFetch, SFetchOk);
    step(1'b0, StDecode, 9'd0);
    step(1'b0, StExec, 9'd0);
    step(1'b0, StWb, SReg);

    // bltz taken, bgez not taken
    instr(6'b000001, 6'd0, 5'b00000);
    step(1'b1, StFetch, SFetchOk);
    step(1'b0, StDecode, 9'd0);
    cyc(1'b0, 1'b1, 1'b0, StExec, SPc, 1'b1, mk_aux(5'd17, 2'b11, 1'b0, 2'd0));
    instr(6'b000001, 6'd0, 5'b00001);
    step(1'b1, StFetch, SFetchOk);
    step(1'b0, StDecode, 9'd0);
    cyc(1'b0, 1'b0, 1'b0, StExec, 9'd0, 1'b1, mk_aux(5'd14, 2'b11, 1'b0, 2'd0));

    // jal resolves in DECODE; jalr in EXEC
    instr(6'b000011, 6'd0, 5'd0);
    step(1'b1, StFetch, SFetchOk);
    step(1'b0, StDecode, SPc | SJmp | SLnk | SReg);
    instr(6'b000000, 6'b001001, 5'd0);
    step(1'b1, StFetch, SFetchOk);
    step(1'b0, StDecode, 9'd0);
    step(1'b0, StExec, SPc | SJr | SLnk | SReg);

    // unknown opcode traps with code 1
    instr(6'b111111, 6'd0, 5'd0);
    step(1'b1, StFetch, SFetchOk);
    step(1'b0, StDecode, 9'd0);
    step(1'b0, StExc, SPc | SExc);
    chk("illegal_code", 32'(if1.exc_code), 32'd1);

    // sw interrupted by reset while waiting in MEM
    instr(6'b101011, 6'd0, 5'd0);
    step(1'b1, StFetch, SFetchOk);
    step(1'b0, StDecode, 9'd0);
    cyc(1'b0, 1'b0, 1'b0, StExec, 9'd0, 1'b1, mk_aux(5'd1, 2'b11, 1'b0, 2'd1));
    step(1'b0, StMem, SWr);
    rst = 1'b1;
    step(1'b0, StMem, SWr);
    cyc(1'b1, 1'b0, 1'b0, StFetch, 9'd0, 1'b1, mk_aux(5'd0, 2'b11, 1'b0, 2'd0));
    rst = 1'b0;
    instr(6'b000000, 6'b100001, 5'd0);
    step(1'b1, StFetch, SFetchOk);
    step(1'b0, StDecode, 9'd0);
    step(1'b0, StExec, 9'd0);
    step(1'b0, StWb, SReg);

    @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multi-cycle control unit for the MIPS core. It replaces the single-cycle combinational decoder with an FSM: FETCH, DECODE, EXEC, MEM, WB, EXC.
It issues per-state control strobes, waits on a memory ready handshake with a timeout, and traps illegal opcodes, arithmetic overflow and bus timeouts.
Optional halfword and byte memory ops are parameter-enabled. It sits between the instruction register and the datapath muxes, the ALU and the data memory port.

Parameters:
TIMEOUT, 15, max cycles to wait for mem_ready before a bus error; 0 disables the timeout; legal range 0..255.
EN_BYTE, 1, 1 makes lb/lbu/sb legal; 0 makes them illegal.
EN_HALF, 1, 1 makes lh(100001)/lhu(100101)/sh(101001) legal; 0 makes them illegal.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- rt  in  5  IR[20:16]; selects bgez (00001) or bltz (00000) for REGIMM.
- br_cond  in  1  ALU branch-condition result, sampled in EXEC.
- ovf  in  1  ALU signed overflow, sampled in EXEC.
- mem_ready  in  1  memory completes the access this cycle.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, EXC=5.
- pc_wr, ir_wr, mem_rd, mem_wr, reg_wr  out  1 each  strobes.
- reg_dst, ext_op, alu_src, mem_to_reg, shamt_ctr, jump, jump_reg, link  out  1 each  registered control word.
- alu_ctr  out  5  registered ALU code.
- byte_width  out  2  01 byte, 10 half, 11 word.
- dm_sign_ext  out  1  sign-extend memory load data.
- exc  out  1  one-cycle trap pulse; PC loads the exception vector.
- exc_code  out  2  0 bus timeout, 1 illegal opcode, 2 overflow; holds until the next trap.

Behaviour:
- Reset values: state=FETCH; all strobes 0; control word 0; alu_ctr=0; byte_width=11; dm_sign_ext=0; exc=0; exc_code=0; timeout counter 0. Reset mid-operation aborts any access; mem_rd and mem_wr drop the next cycle.
- Strobes are combinational from state plus the registered word. The control word is registered on DECODE exit.
- ALU codes: add/addu/addi/addiu/loads/stores=1, sub/subu=2, and/andi=3, or/ori=4, xor/xori=5, nor=6, slt/slti=7, sltu/sltiu=8, sll/sllv=9, srl/srlv=10, sra/srav=11, beq=12, bne=13, bgez=14, bgtz=15, blez=16, bltz=17, lui=18.
- ext_op=1 for arithmetic immediates, slt immediates, memory ops and branches; 0 for andi/ori/xori/lui.
- shamt_ctr=1 only for sll/srl/sra.
- Overflow is checked only for add/sub/addi.
- FETCH:
  - mem_rd=1 while waiting.
  - On mem_ready: ir_wr=1 and pc_wr=1 (PC+4) in the same cycle, go to DECODE.
  - Counter increments on each non-ready cycle. At count==TIMEOUT with no ready (TIMEOUT≠0): go to EXC, code 0.
- DECODE (1 cycle):
  - Unknown opcode or funct, or a disabled byte/half op: EXC, code 1.
  - j: pc_wr=1, jump=1, go to FETCH.
  - jal: same, plus link=1 and reg_wr=1 (writes r31).
  - All else: EXEC.
- EXEC (1 cycle):
  - Branch: pc_wr=br_cond, go to FETCH.
  - jr: pc_wr=1, jump_reg=1, go to FETCH.
  - jalr: additionally reg_wr=1 and link=1.
  - Load/store: MEM.
  - ALU op with overflow check and ovf=1: EXC, code 2, no register write. Otherwise WB.
- MEM:
  - Load holds mem_rd=1; store holds mem_wr=1, until mem_ready.
  - On ready: load goes to WB, store goes to FETCH.
  - Timeout as in FETCH (counter cleared on every state entry): EXC, code 0.
- WB: reg_wr=1 for 1 cycle, go to FETCH.
- EXC: exc=1 and pc_wr=1 for 1 cycle, go to FETCH. No reg_wr or mem_wr ever issues in EXC.
- Latencies in cycles, excluding memory wait: ALU op 4, load 5, store 4, branch/jr 3, j/jal 2, trap +1.
- mem_ready asserted outside FETCH/MEM is ignored. mem_ready in the same cycle as the timeout hit wins; there is no trap.

Test Plan:
- Reset, then addu (op 0, funct 100001) with mem_ready=1 → states 0,1,2,4,0; reg_wr=1 only in WB; alu_ctr=1.
- lh with EN_HALF=1, memory ready after 3 waits → MEM holds mem_rd 4 cycles; byte_width=10; dm_sign_ext=1; WB reg_wr. Same op with EN_HALF=0 → EXC, exc_code=1.
- add with ovf=1 in EXEC → EXC next cycle; exc=1 for 1 cycle; exc_code=2; no reg_wr. addu with ovf=1 → WB normally.
- TIMEOUT=15, mem_ready held 0 in FETCH → exc after 16 FETCH cycles, exc_code=0. mem_ready=1 on cycle 16 → no trap.
- bltz (op 000001, rt=0) with br_cond=1 → alu_ctr=17, pc_wr in EXEC. bgez with br_cond=0 → no pc_wr. jal → pc_wr, link, reg_wr in DECODE.
- rst asserted in MEM during a store wait → next cycle state=0, mem_wr=0, all outputs at reset values.
